freq_meter: RTL and testbench

- Downstream measurement stage for the frequency-divider family: consumes a divided clock (clk_out of a divider) as a data signal sampled on the fast clk_in.
- Counts rising edges and high-time cycles of the input over a fixed gate window of clk_in cycles.
- Publishes latched results with a one-cycle valid strobe. Used to self-check divider ratio and duty cycle in system and on the bench.

---
 rtl/freq_meter.sv | 124 ++++++++++++
 tb/tb_freq_meter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// freq_meter: measures rising edges and high time of an asynchronous input
// (typically a divider clk_out) over a fixed gate window of clk_in cycles.
// Results are latched at the end of each window with a one-cycle valid strobe.
module freq_meter #(
  parameter int GATE_CYCLES = 60,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] count_out,
  output logic [CNT_W-1:0] high_out,
  output logic             overflow,
  output logic             valid,
  output logic             busy
);

  localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic                   w_start;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sig_prev;
  logic                   w_sig_s;
  logic                   w_rise;
  logic                   w_gate_last;
  logic [GW-1:0]          r_gate;
  logic [CNT_W-1:0]       r_edge;
  logic [CNT_W-1:0]       r_high;
  logic                   r_ovf;

  assign w_sig_s     = r_sync[SYNC_STAGES-1];
  assign w_rise      = w_sig_s & ~r_sig_prev;
  assign w_gate_last = (r_gate == GW'(GATE_CYCLES - 1));
  assign busy        = (r_state != IDLE);

  // Input synchronizer and previous-sample register, running in every state
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_sync     <= '0;
      r_sig_prev <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_sig_prev <= w_sig_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; w_start marks entry into a fresh window
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_next  = MEASURE;
          w_start = 1'b1;
        end
      end
      MEASURE: begin
        if (!enable)         w_next = IDLE;
        else if (w_gate_last) w_next = DONE;
      end
      DONE: begin
        if (enable) begin
          w_next  = MEASURE;
          w_start = 1'b1;
        end else begin
          w_next  = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Gate, edge and high-time counters with saturation and overflow flag
  always_ff @(posedge clk_in) begin
    if (reset || w_start) begin
      r_gate <= '0;
      r_edge <= '0;
      r_high <= '0;
      r_ovf  <= 1'b0;
    end else if (r_state == MEASURE) begin
      r_gate <= r_gate + 1'b1;
      if (w_rise) begin
        if (r_edge == '1) r_ovf  <= 1'b1;
        else              r_edge <= r_edge + 1'b1;
      end
      if (w_sig_s) begin
        if (r_high == '1) r_ovf  <= 1'b1;
        else              r_high <= r_high + 1'b1;
      end
    end
  end

  // Result latch: outputs and valid strobe appear together the cycle after DONE
  always_ff @(posedge clk_in) begin
    if (reset) begin
      count_out <= '0;
      high_out  <= '0;
      overflow  <= 1'b0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (r_state == DONE) begin
        count_out <= r_edge;
        high_out  <= r_high;
        overflow  <= r_ovf;
        valid     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Directed self-checking bench for freq_meter (default build and CNT_W=4 build).
module tb_freq_meter;

  logic        clk_in = 1'b0;
  logic        reset, enable, sig_in;
  logic        en4, sig4;
  logic [15:0] count_out, high_out;
  logic        overflow, valid, busy;
  logic [3:0]  count4, high4;
  logic        ovf4, valid4, busy4;

  int errors = 0;
  int checks = 0;
  int mode   = 0;   // 0: sig_in=0, 1: sig_in=1, 2: 1 high / 2 low, 3: toggle
  int phase  = 0;
  bit tog4   = 1'b0;
  int n;

  always #5 clk_in = ~clk_in;

  freq_meter #(.GATE_CYCLES(60), .CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk_in(clk_in), .reset(reset), .enable(enable), .sig_in(sig_in),
    .count_out(count_out), .high_out(high_out), .overflow(overflow),
    .valid(valid), .busy(busy)
  );

  freq_meter #(.GATE_CYCLES(60), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
    .clk_in(clk_in), .reset(reset), .enable(en4), .sig_in(sig4),
    .count_out(count4), .high_out(high4), .overflow(ovf4),
    .valid(valid4), .busy(busy4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs update and outputs are read 1 time unit after the edge
  task automatic step();
    @(posedge clk_in);
    #1;
    case (mode)
      0: sig_in = 1'b0;
      1: sig_in = 1'b1;
      2: begin phase = (phase + 1) % 3; sig_in = (phase == 0); end
      default: sig_in = ~sig_in;
    endcase
    if (tog4) sig4 = ~sig4;
  endtask

  task automatic wait_valid(input bit sel, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!(sel ? valid4 : valid) && cnt < 200);
  endtask

  task automatic chk_res(input string tag, input int c, input int h, input int o);
    chk({tag, "_count"}, 32'(count_out), 32'(c));
    chk({tag, "_high"},  32'(high_out),  32'(h));
    chk({tag, "_ovf"},   32'(overflow),  32'(o));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; sig_in = 1'b0; en4 = 1'b0; sig4 = 1'b0;
    mode = 3;
    // Reset held 3 cycles with enable high and toggling input
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_count", 32'(count_out), 0);
      chk("rst_high",  32'(high_out),  0);
      chk("rst_ovf",   32'(overflow),  0);
      chk("rst_valid", 32'(valid),     0);
      chk("rst_busy",  32'(busy),      0);
    end
    reset = 1'b0;
    step();
    chk("busy_after_rst", 32'(busy), 1);
    enable = 1'b0;
    step();
    chk("abort_idle_busy", 32'(busy), 0);

    // Divide-by-3 pattern, two back-to-back windows
    mode = 2;
    repeat (5) step();
    enable = 1'b1;
    step();
    wait_valid(1'b0, n);
    chk("div3_latency1", 32'(n), 61);
    chk_res("div3_w1", 20, 20, 0);
    wait_valid(1'b0, n);
    chk("div3_period", 32'(n), 61);
    chk_res("div3_w2", 20, 20, 0);
    step();
    chk("valid_one_cycle", 32'(valid), 0);

    // Abort 30 cycles into a window: results retained, no valid
    repeat (29) step();
    enable = 1'b0;
    step();
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(valid), 0);
    chk_res("abort_hold", 20, 20, 0);
    repeat (3) step();
    chk("abort_no_valid", 32'(valid), 0);

    // Constant-high input established before enable
    mode = 1;
    repeat (5) step();
    enable = 1'b1;
    step();
    wait_valid(1'b0, n);
    chk("const1_latency", 32'(n), 61);
    chk_res("const1_w1", 0, 60, 0);
    wait_valid(1'b0, n);
    chk("const1_period", 32'(n), 61);
    chk_res("const1_w2", 0, 60, 0);

    // Reset mid-window; restart sees the synchronizer refill as one rise
    repeat (20) step();
    reset = 1'b1;
    step();
    chk_res("midrst", 0, 0, 0);
    chk("midrst_valid", 32'(valid), 0);
    chk("midrst_busy",  32'(busy),  0);
    step();
    reset = 1'b0;
    step();
    chk("restart_busy", 32'(busy), 1);
    wait_valid(1'b0, n);
    chk("restart_latency", 32'(n), 61);
    chk_res("restart", 1, 59, 0);

    // CNT_W=4: toggling saturates both counters
    tog4 = 1'b1;
    repeat (4) step();
    en4 = 1'b1;
    step();
    wait_valid(1'b1, n);
    chk("sat_latency", 32'(n), 61);
    chk("sat_count", 32'(count4), 15);
    chk("sat_high",  32'(high4),  15);
    chk("sat_ovf",   32'(ovf4),   1);
    tog4 = 1'b0; sig4 = 1'b0; en4 = 1'b0;
    step();
    chk("sat_abort_busy", 32'(busy4), 0);
    repeat (5) step();
    en4 = 1'b1;
    step();
    wait_valid(1'b1, n);
    chk("zero_latency", 32'(n), 61);
    chk("zero_count", 32'(count4), 0);
    chk("zero_high",  32'(high4),  0);
    chk("zero_ovf",   32'(ovf4),   0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
